// File: rtl/leb128_pkg.sv
// rtl/leb128_pkg.sv - shared constants and types for the LEB128 stream decoder
package leb128_pkg;

    localparam int LEB128_MAX_BYTES = 10;
    localparam int LEB128_LEN_W     = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } leb128_state_e;

    // byte 0 of the encoding sits in bits [7:0]
    typedef logic [LEB128_MAX_BYTES-1:0][7:0] leb128_window_t;

endpackage

// File: rtl/unpack_i64.sv
// rtl/unpack_i64.sv - combinational signed 64-bit LEB128 decoder over a 10-byte window
module unpack_i64 (
    input  logic [79:0] in_bytes,
    output logic [63:0] out_value
);

    logic [63:0] raw;
    logic [6:0]  nbits;
    logic        done;

    // gather payload bits up to the terminator, track payload width, then sign-extend from its top bit
    always_comb begin
        raw   = '0;
        nbits = 7'd70;
        done  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!done) begin
                raw = raw | (64'(in_bytes[8*i +: 7]) << (7 * i));
                if (!in_bytes[8*i + 7]) begin
                    nbits = 7'(7 * (i + 1));
                    done  = 1'b1;
                end
            end
        end
        out_value = raw;
        if (nbits < 7'd64) begin
            if (raw[6'(nbits - 7'd1)]) begin
                out_value = raw | (~64'd0 << nbits);
            end
        end
    end

endmodule

// File: rtl/unpack_u64.sv
// rtl/unpack_u64.sv - combinational unsigned 64-bit LEB128 decoder over a 10-byte window
module unpack_u64 (
    input  logic [79:0] in_bytes,
    output logic [63:0] out_value
);

    logic done;

    // accumulate 7-bit groups up to and including the first terminating byte
    always_comb begin
        out_value = '0;
        done      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!done) begin
                out_value = out_value | (64'(in_bytes[8*i +: 7]) << (7 * i));
            end
            if (!in_bytes[8*i + 7]) begin
                done = 1'b1;
            end
        end
    end

endmodule

// File: rtl/leb128_stream_dec.sv
// rtl/leb128_stream_dec.sv - byte-serial LEB128 sequencer, optional LEB128_STATS_EN counters
module leb128_stream_dec
    import leb128_pkg::*;
#(
    parameter bit SIGNED    = 1'b1,
    parameter int MAX_BYTES = LEB128_MAX_BYTES
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    flush,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [63:0]             out_data,
    output logic [LEB128_LEN_W-1:0] out_len,
    output logic                    out_err,
    output logic                    out_valid,
`ifdef LEB128_STATS_EN
    output logic [31:0]             frame_cnt,
    output logic [15:0]             err_cnt,
`endif
    input  logic                    out_ready
);

    leb128_state_e          state, state_n;
    logic [LEB128_LEN_W-1:0] cnt;
    leb128_window_t         window;
    leb128_window_t         dec_win;
    logic [63:0]            dec_value;
    logic                   rdy_en;
    logic                   accept, out_fire, terminate, overflow;
    logic                   load_res, clr_win, add_byte;

    assign out_valid = (state == HOLD);
    assign in_ready  = rdy_en & ~flush & ((state == COLLECT) | out_ready);
    assign accept    = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign terminate = accept & ~in_data[7];
    assign overflow  = accept & in_data[7] & (cnt == LEB128_LEN_W'(MAX_BYTES - 1));

    // window as the decoder should see it: stored bytes plus the incoming byte at slot cnt
    always_comb begin
        dec_win = window;
        for (int i = 0; i < LEB128_MAX_BYTES; i++) begin
            if (LEB128_LEN_W'(i) == cnt) begin
                dec_win[i] = in_data;
            end
        end
    end

    generate
        if (SIGNED) begin : g_signed
            unpack_i64 u_dec (.in_bytes(dec_win), .out_value(dec_value));
        end else begin : g_unsigned
            unpack_u64 u_dec (.in_bytes(dec_win), .out_value(dec_value));
        end
    endgenerate

    // next state and datapath controls; window and cnt are already cleared whenever HOLD is entered
    always_comb begin
        state_n  = state;
        load_res = 1'b0;
        clr_win  = 1'b0;
        add_byte = 1'b0;
        if (flush) begin
            state_n = COLLECT;
            clr_win = 1'b1;
        end else begin
            case (state)
                COLLECT: begin
                    if (terminate || overflow) begin
                        state_n  = HOLD;
                        load_res = 1'b1;
                        clr_win  = 1'b1;
                    end else if (accept) begin
                        add_byte = 1'b1;
                    end
                end
                HOLD: begin
                    if (out_fire) begin
                        if (terminate) begin
                            load_res = 1'b1;
                            clr_win  = 1'b1;
                        end else if (accept) begin
                            state_n  = COLLECT;
                            add_byte = 1'b1;
                        end else begin
                            state_n = COLLECT;
                        end
                    end
                end
                default: state_n = COLLECT;
            endcase
        end
    end

    // state register and the ready enable that opens one cycle after reset release
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= COLLECT;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_n;
            rdy_en <= 1'b1;
        end
    end

    // byte window and fill count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            window <= '0;
            cnt    <= '0;
        end else if (clr_win) begin
            window <= '0;
            cnt    <= '0;
        end else if (add_byte) begin
            window <= dec_win;
            cnt    <= cnt + LEB128_LEN_W'(1);
        end
    end

    // result register, held stable while HOLD waits for out_ready
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_data <= '0;
            out_len  <= '0;
            out_err  <= 1'b0;
        end else if (load_res) begin
            out_data <= overflow ? 64'd0 : dec_value;
            out_len  <= cnt + LEB128_LEN_W'(1);
            out_err  <= overflow;
        end
    end

`ifdef LEB128_STATS_EN
    // handshake counters; flush never clears them
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else if (out_fire && !flush) begin
            frame_cnt <= frame_cnt + 32'd1;
            if (out_err && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_leb128_stream_dec.sv
// tb/tb_leb128_stream_dec.sv - self-checking bench for leb128_stream_dec (signed and unsigned instances)
module tb_leb128_stream_dec;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        rdy_u, rdy_s, ov_u, ov_s, err_u, err_s;
    logic [63:0] data_u, data_s;
    logic [3:0]  len_u, len_s;
`ifdef LEB128_STATS_EN
    logic [31:0] fc_u, fc_s;
    logic [15:0] ec_u, ec_s;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    leb128_stream_dec #(.SIGNED(1'b0)) dut_u (
        .clk(clk), .rstn(rstn), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_u), .out_data(data_u), .out_len(len_u), .out_err(err_u), .out_valid(ov_u),
`ifdef LEB128_STATS_EN
        .frame_cnt(fc_u), .err_cnt(ec_u),
`endif
        .out_ready(out_ready)
    );

    leb128_stream_dec #(.SIGNED(1'b1)) dut_s (
        .clk(clk), .rstn(rstn), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_s), .out_data(data_s), .out_len(len_s), .out_err(err_s), .out_valid(ov_s),
`ifdef LEB128_STATS_EN
        .frame_cnt(fc_s), .err_cnt(ec_s),
`endif
        .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [63:0] u;
        logic [63:0] s;
        logic [3:0]  len;
        logic        err;
    } res_t;

    res_t        expq[$];
    logic [7:0]  frame[$];
    logic        alive;
    int unsigned m_frames, m_errs;
    logic        s_acc, s_hs, s_flush;
    logic [7:0]  s_byte;

    // value of a finished frame straight from the LEB128 definition
    function automatic res_t model(input logic [7:0] f[$]);
        res_t         r;
        logic [127:0] acc;
        int           n;
        acc = '0;
        n   = f.size();
        for (int i = 0; i < n; i++) begin
            acc = acc + 128'(f[i][6:0]) * (128'd1 << (7 * i));
        end
        r.u   = acc[63:0];
        r.s   = acc[63:0];
        if (n <= 9 && acc[7*n-1]) r.s = acc[63:0] - (64'd1 << (7 * n));
        r.len = 4'(n);
        r.err = f[n-1][7];
        if (r.err) begin
            r.u = '0;
            r.s = '0;
        end
        return r;
    endfunction

    // reference: consume the handshakes observed before each edge
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            expq.delete();
            frame.delete();
            alive    = 1'b0;
            m_frames = 0;
            m_errs   = 0;
        end else begin
            if (s_flush) begin
                expq.delete();
                frame.delete();
            end else begin
                if (s_hs && expq.size() != 0) begin
                    m_frames++;
                    if (expq[0].err && m_errs != 65535) m_errs++;
                    void'(expq.pop_front());
                end
                if (s_acc) begin
                    frame.push_back(s_byte);
                    if (!s_byte[7] || frame.size() == 10) begin
                        expq.push_back(model(frame));
                        frame.delete();
                    end
                end
            end
            alive = 1'b1;
        end
    end

    // compare process: sample handshakes and check every output mid-cycle
    always @(negedge clk) begin
        s_acc   = in_valid && rdy_u;
        s_hs    = ov_u && out_ready;
        s_flush = flush;
        s_byte  = in_data;
        if (!rstn) begin
            chk("rst_valid", {63'd0, ov_u | ov_s}, 64'd0);
            chk("rst_ready", {63'd0, rdy_u | rdy_s}, 64'd0);
        end else begin
            chk("in_ready_u", {63'd0, rdy_u}, {63'd0, alive && !flush && (expq.size() == 0 || out_ready)});
            chk("in_ready_s", {63'd0, rdy_s}, {63'd0, alive && !flush && (expq.size() == 0 || out_ready)});
            chk("out_valid_u", {63'd0, ov_u}, {63'd0, expq.size() != 0});
            chk("out_valid_s", {63'd0, ov_s}, {63'd0, expq.size() != 0});
            if (expq.size() != 0) begin
                chk("data_u", data_u, expq[0].u);
                chk("data_s", data_s, expq[0].s);
                chk("len_u", {60'd0, len_u}, {60'd0, expq[0].len});
                chk("len_s", {60'd0, len_s}, {60'd0, expq[0].len});
                chk("err_u", {63'd0, err_u}, {63'd0, expq[0].err});
                chk("err_s", {63'd0, err_s}, {63'd0, expq[0].err});
            end
`ifdef LEB128_STATS_EN
            chk("frame_cnt_u", {32'd0, fc_u}, {32'd0, m_frames});
            chk("frame_cnt_s", {32'd0, fc_s}, {32'd0, m_frames});
            chk("err_cnt_u", {48'd0, ec_u}, 64'(m_errs));
            chk("err_cnt_s", {48'd0, ec_s}, 64'(m_errs));
`endif
        end
    end

    // drive one cycle of inputs; called and returns 2 time units after a rising edge
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [63:0] u, input logic [63:0] s,
                       input logic [3:0] len, input logic err);
        chk({name, "_valid"}, {63'd0, ov_u & ov_s}, 64'd1);
        chk({name, "_u"}, data_u, u);
        chk({name, "_s"}, data_s, s);
        chk({name, "_len"}, {60'd0, len_u}, {60'd0, len});
        chk({name, "_err"}, {63'd0, err_u}, {63'd0, err});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("reset_data", data_u | data_s, 64'd0);
        chk("reset_len", {60'd0, len_u | len_s}, 64'd0);
        chk("reset_err", {63'd0, err_u | err_s}, 64'd0);
        rstn = 1'b1;
        chk("ready_after_release", {63'd0, rdy_u}, 64'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("ready_one_cycle_later", {63'd0, rdy_u}, 64'd1);

        for (int i = 0; i < 9; i++) step(1'b1, 8'hFF, 1'b1, 1'b0);
        step(1'b1, 8'h01, 1'b1, 1'b0);
        lit("ff9_01", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b0);
        step(1'b1, 8'hE5, 1'b1, 1'b0);
        step(1'b1, 8'h8E, 1'b1, 1'b0);
        step(1'b1, 8'h26, 1'b1, 1'b0);
        lit("e58e26", 64'd624485, 64'd624485, 4'd3, 1'b0);
        step(1'b1, 8'hC0, 1'b1, 1'b0);
        step(1'b1, 8'hBB, 1'b1, 1'b0);
        step(1'b1, 8'h78, 1'b1, 1'b0);
        lit("c0bb78", 64'd1973696, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 1'b0);
        step(1'b1, 8'h7F, 1'b1, 1'b0);
        lit("7f", 64'd127, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 1'b0);

        step(1'b1, 8'h01, 1'b1, 1'b0);
        lit("b2b_1", 64'd1, 64'd1, 4'd1, 1'b0);
        step(1'b1, 8'h02, 1'b1, 1'b0);
        lit("b2b_2", 64'd2, 64'd2, 4'd1, 1'b0);
        chk("b2b_ready", {63'd0, rdy_u}, 64'd1);
        step(1'b1, 8'h03, 1'b1, 1'b0);
        lit("b2b_3", 64'd3, 64'd3, 4'd1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        step(1'b1, 8'h7F, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h05, 1'b0, 1'b0);
            lit("bp_hold", 64'd127, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 1'b0);
            chk("bp_ready", {63'd0, rdy_u}, 64'd0);
        end
        step(1'b1, 8'h05, 1'b1, 1'b0);
        lit("bp_next", 64'd5, 64'd5, 4'd1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 10; i++) step(1'b1, 8'h80, 1'b1, 1'b0);
        lit("overflow", 64'd0, 64'd0, 4'd10, 1'b1);
        step(1'b1, 8'h05, 1'b1, 1'b0);
        lit("after_ovf", 64'd5, 64'd5, 4'd1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        step(1'b1, 8'h80, 1'b1, 1'b0);
        step(1'b1, 8'h80, 1'b1, 1'b0);
        step(1'b1, 8'h2A, 1'b1, 1'b1);
        step(1'b1, 8'h2A, 1'b1, 1'b0);
        lit("after_flush", 64'd42, 64'd42, 4'd1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        step(1'b1, 8'h80, 1'b1, 1'b0);
        step(1'b1, 8'h80, 1'b1, 1'b0);
`ifdef LEB128_STATS_EN
        chk("stats_frames", {32'd0, fc_u}, 64'd12);
        chk("stats_errs", {48'd0, ec_u}, 64'd1);
`endif
        in_valid = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        #2;
        rstn = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h2A, 1'b1, 1'b0);
        lit("after_reset", 64'd42, 64'd42, 4'd1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
`ifdef LEB128_STATS_EN
        chk("stats_after_reset", {32'd0, fc_u}, 64'd1);
`endif

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if ($urandom_range(99) < 85) b[7] = 1'b1;
            else b[7] = 1'b0;
            step(($urandom_range(3) != 0), b, ($urandom_range(3) != 0), ($urandom_range(199) == 0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
